fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter T, default 10, program-counter width in bits.
REQ-002 SHALL have parameter W, default 8, jump-target width; W <= T.
REQ-003 SHALL have parameter D, default 4, return-address-stack (RAS) depth, D >= 2.
REQ-004 SHALL have port Clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port Reset  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port Stall  input  1  freeze all state this cycle.
REQ-007 SHALL have port Done  input  1  program-complete request.
REQ-008 SHALL have port BrOp  input  3  branch operation, br_op_t encoding.
REQ-009 SHALL have port Zero  input  1  ALU zero flag.
REQ-010 SHALL have port Target  input  W  jump target, absolute low bits or signed offset.
REQ-011 SHALL have port ProgCtr  output  T  current PC.
REQ-012 SHALL have port ProgCtr_p1  output  T  ProgCtr+1 mod 2^T, combinational.
REQ-013 SHALL have port RasDepth  output  $clog2(D+1)  valid RAS entries.
REQ-014 SHALL have port RasOvf  output  1  sticky, a push dropped an entry.
REQ-015 SHALL have port RasUnf  output  1  sticky, a pop found the stack empty.
REQ-016 SHALL have port Halted  output  1  sticky, fetch stopped by Done.

Function
REQ-017 Priority per cycle SHALL be Reset > Stall > Halted > BrOp > Done > increment.
REQ-018 Stall=1 SHALL hold PC, RAS, all flags; BrOp and Done ignored that cycle.
REQ-019 Halted=1 SHALL hold PC and RAS; all inputs except Reset ignored.
REQ-020 BR_NONE: Done=1 SHALL hold PC and set Halted next edge; else PC <= PC+1, wrapping 2^T-1 -> 0.
REQ-021 BR_ALW SHALL load PC[W-1:0] <= Target, PC[T-1:W] unchanged.
REQ-022 BR_EZ SHALL do the REQ-021 load when Zero=1, else behave as BR_NONE.
REQ-023 BR_NZ SHALL do the REQ-021 load when Zero=0, else behave as BR_NONE.
REQ-024 BR_CALL SHALL push ProgCtr_p1 and do the REQ-021 load in the same edge.
REQ-025 CALL when RasDepth=D SHALL overwrite the oldest entry (circular), keep RasDepth=D, set RasOvf.
REQ-026 BR_RET with RasDepth>0 SHALL set PC <= top entry (full T bits) and decrement RasDepth.
REQ-027 BR_RET with RasDepth=0 SHALL act as BR_NONE and set RasUnf; RasDepth stays 0.
REQ-028 A taken branch, CALL or RET SHALL override Done; Done is honoured only on non-redirecting cycles.
REQ-029 Redirect latency SHALL be one edge: new PC visible on ProgCtr the cycle after BrOp is presented.
REQ-030 RAS pointer arithmetic SHALL wrap modulo D for any D, including non-power-of-two.

Reset
REQ-031 Reset SHALL set ProgCtr=0, RasDepth=0, RasOvf=0, RasUnf=0, Halted=0, so ProgCtr_p1=1.
REQ-032 Reset SHALL take effect on the next edge regardless of Stall, Halted or BrOp, including mid-CALL/RET.
REQ-033 RAS entry contents SHALL be don't-care after reset; entries are readable only when RasDepth>0.

Configuration
REQ-034 Macro FETCH_REL_BRANCH_EN defined SHALL enable BR_REL_EZ/BR_REL_NZ: when taken, PC <= PC + sign-extended Target, mod 2^T.
REQ-035 Macro FETCH_REL_BRANCH_EN undefined SHALL decode BR_REL_EZ/BR_REL_NZ as BR_NONE with no relative adder in the design.

Structure
REQ-036 Package fetch_pkg SHALL hold br_op_t: BR_NONE=0, BR_EZ=1, BR_NZ=2, BR_ALW=3, BR_CALL=4, BR_RET=5, BR_REL_EZ=6, BR_REL_NZ=7.
REQ-037 fetch_pkg SHALL hold the default values of T, W and D.
REQ-038 The RAS SHALL be sub-module ras_stack (params T, D; push, pop, top, depth, ovf, unf).

Verification
REQ-039 Bench: Reset, then 5 idle cycles -> ProgCtr 0,1,2,3,4,5 with ProgCtr_p1 always ProgCtr+1.
REQ-040 Bench: PC=0x1F0, BR_ALW Target=0x22 -> PC=0x122; BR_EZ Zero=0 -> PC=0x123.
REQ-041 Bench: D=4, five CALLs, then five RETs -> RasOvf=1 after the 5th CALL; RETs return the 5th..2nd return addresses; the 5th RET raises RasUnf and increments PC.
REQ-042 Bench: Stall=1 during BR_CALL -> PC, RasDepth unchanged; CALL executes the cycle Stall drops.
REQ-043 Bench: Done=1 with BR_ALW -> branch taken, Halted=0; Done=1 next with BR_NONE -> Halted=1 and PC frozen until Reset.
REQ-044 Bench (FETCH_REL_BRANCH_EN): PC=0x005, BR_REL_NZ Zero=0 Target=0xFA (-6) -> PC=0x3FF with T=10.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default parameters for the instruction fetch controller.
// Optional relative branches are enabled by defining FETCH_REL_BRANCH_EN.
package fetch_pkg;

    localparam int DEF_T = 10;  // program-counter width
    localparam int DEF_W = 8;   // jump-target width
    localparam int DEF_D = 4;   // return-address-stack depth

    typedef enum logic [2:0] {
        BR_NONE   = 3'd0,
        BR_EZ     = 3'd1,
        BR_NZ     = 3'd2,
        BR_ALW    = 3'd3,
        BR_CALL   = 3'd4,
        BR_RET    = 3'd5,
        BR_REL_EZ = 3'd6,
        BR_REL_NZ = 3'd7
    } br_op_t;

    typedef enum logic {
        RUNNING = 1'b0,
        HALTED  = 1'b1
    } run_state_t;

endpackage

// File: rtl/fetch_ctrl_ras_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// a pop when empty only raises the sticky underflow flag.
module ras_stack
    import fetch_pkg::*;
#(
    parameter int T = DEF_T,
    parameter int D = DEF_D
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [T-1:0]             push_data,
    output logic [T-1:0]             top,
    output logic [$clog2(D+1)-1:0]   depth,
    output logic                     ovf,
    output logic                     unf
);

    localparam int PW = $clog2(D);
    localparam int DW = $clog2(D+1);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [T-1:0]  mem [D];
    logic          full;
    logic          empty;

    // Explicit compare-and-wrap keeps non-power-of-two depths correct.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(D-1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PW-1:0] wrap_dec(input logic [PW-1:0] p);
        return (p == '0) ? PW'(D-1) : p - 1'b1;
    endfunction

    assign rd_ptr = wrap_dec(wr_ptr);
    assign top    = mem[rd_ptr];
    assign full   = (depth == DW'(D));
    assign empty  = (depth == '0);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr <= '0;
            depth  <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else if (push) begin
            wr_ptr <= wrap_inc(wr_ptr);
            if (full) ovf <= 1'b1;
            else      depth <= depth + 1'b1;
        end else if (pop) begin
            if (empty) begin
                unf <= 1'b1;
            end else begin
                wr_ptr <= rd_ptr;
                depth  <= depth - 1'b1;
            end
        end
    end

    // NOTE: storage is deliberately not reset; entries are only read while depth > 0.
    always_ff @(posedge Clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Program-counter sequencer with conditional/absolute branches, call/return
// stack and halt. Relative branches exist only with FETCH_REL_BRANCH_EN defined.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int T = DEF_T,
    parameter int W = DEF_W,
    parameter int D = DEF_D
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Stall,
    input  logic                     Done,
    input  logic [2:0]               BrOp,
    input  logic                     Zero,
    input  logic [W-1:0]             Target,
    output logic [T-1:0]             ProgCtr,
    output logic [T-1:0]             ProgCtr_p1,
    output logic [$clog2(D+1)-1:0]   RasDepth,
    output logic                     RasOvf,
    output logic                     RasUnf,
    output logic                     Halted
);

    // Absolute jumps replace only the low W bits of the PC.
    localparam logic [T-1:0] LOW_MASK = {T{1'b1}} >> (T - W);

    br_op_t     op;
    run_state_t state;
    run_state_t state_next;
    logic [T-1:0] pc;
    logic [T-1:0] pc_next;
    logic [T-1:0] abs_target;
    logic [T-1:0] ras_top;
    logic         push;
    logic         pop;
    logic         go_halt;

    assign op         = br_op_t'(BrOp);
    assign ProgCtr    = pc;
    assign ProgCtr_p1 = pc + 1'b1;
    assign abs_target = (pc & ~LOW_MASK) | T'(Target);

`ifdef FETCH_REL_BRANCH_EN
    logic [T-1:0] rel_target;
    assign rel_target = pc + T'($signed(Target));
`endif

    // Datapath decode: the sequential default is overridden by any redirect,
    // which is how a taken branch wins over Done.
    always_comb begin
        // NOTE: blocking assignments with defaults first keep this purely combinational.
        pc_next = pc;
        push    = 1'b0;
        pop     = 1'b0;
        go_halt = 1'b0;
        if (!Stall && state == RUNNING) begin
            if (Done) go_halt = 1'b1;
            else      pc_next = ProgCtr_p1;
            case (op)
                BR_ALW: begin
                    pc_next = abs_target;
                    go_halt = 1'b0;
                end
                BR_EZ: if (Zero) begin
                    pc_next = abs_target;
                    go_halt = 1'b0;
                end
                BR_NZ: if (!Zero) begin
                    pc_next = abs_target;
                    go_halt = 1'b0;
                end
                BR_CALL: begin
                    pc_next = abs_target;
                    go_halt = 1'b0;
                    push    = 1'b1;
                end
                BR_RET: begin
                    pop = 1'b1;
                    if (RasDepth != '0) begin
                        pc_next = ras_top;
                        go_halt = 1'b0;
                    end
                end
`ifdef FETCH_REL_BRANCH_EN
                BR_REL_EZ: if (Zero) begin
                    pc_next = rel_target;
                    go_halt = 1'b0;
                end
                BR_REL_NZ: if (!Zero) begin
                    pc_next = rel_target;
                    go_halt = 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge Clk) begin
        if (Reset) pc <= '0;
        else       pc <= pc_next;
    end

    always_ff @(posedge Clk) begin
        if (Reset) state <= RUNNING;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == RUNNING && go_halt) state_next = HALTED;
    end

    always_comb begin
        Halted = (state == HALTED);
    end

    ras_stack #(
        .T (T),
        .D (D)
    ) u_ras (
        .Clk       (Clk),
        .Reset     (Reset),
        .push      (push),
        .pop       (pop),
        .push_data (ProgCtr_p1),
        .top       (ras_top),
        .depth     (RasDepth),
        .ovf       (RasOvf),
        .unf       (RasUnf)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table plus randomized
// traffic against a queue-based reference model.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam int T     = 10;
    localparam int W     = 8;
    localparam int D     = 4;
    localparam int PCMOD = 1 << T;
    localparam int TMOD  = 1 << W;

    logic         Clk = 1'b0;
    logic         Reset, Stall, Done, Zero;
    logic [2:0]   BrOp;
    logic [W-1:0] Target;
    logic [T-1:0] ProgCtr, ProgCtr_p1;
    logic [$clog2(D+1)-1:0] RasDepth;
    logic         RasOvf, RasUnf, Halted;

    fetch_ctrl #(.T(T), .W(W), .D(D)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Stall      (Stall),
        .Done       (Done),
        .BrOp       (BrOp),
        .Zero       (Zero),
        .Target     (Target),
        .ProgCtr    (ProgCtr),
        .ProgCtr_p1 (ProgCtr_p1),
        .RasDepth   (RasDepth),
        .RasOvf     (RasOvf),
        .RasUnf     (RasUnf),
        .Halted     (Halted)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input int pc, input int depth,
                                 input bit ovf, input bit unf, input bit hlt);
        check({tag, ".pc"},    32'(ProgCtr),    pc);
        check({tag, ".pc_p1"}, 32'(ProgCtr_p1), (pc + 1) % PCMOD);
        check({tag, ".depth"}, 32'(RasDepth),   depth);
        check({tag, ".ovf"},   32'(RasOvf),     32'(ovf));
        check({tag, ".unf"},   32'(RasUnf),     32'(unf));
        check({tag, ".halt"},  32'(Halted),     32'(hlt));
    endtask

    // Apply one cycle of inputs, then sample one time unit after the edge.
    task automatic drive(input bit r, input bit s, input bit d, input br_op_t op,
                         input bit z, input int tgt);
        Reset  = r;
        Stall  = s;
        Done   = d;
        BrOp   = op;
        Zero   = z;
        Target = W'(tgt);
        @(posedge Clk);
        #1;
    endtask

    typedef struct {
        bit     rst, stl, dn;
        br_op_t op;
        bit     z;
        int     tgt;
        int     pc, depth;
        bit     ovf, unf, hlt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit r, bit s, bit d, br_op_t op, bit z, int tgt,
                                int pc, int depth, bit ovf, bit unf, bit hlt);
        vec_t v;
        v.rst = r; v.stl = s; v.dn = d; v.op = op; v.z = z; v.tgt = tgt;
        v.pc = pc; v.depth = depth; v.ovf = ovf; v.unf = unf; v.hlt = hlt;
        vecs.push_back(v);
    endfunction

    // Reference model: PC as an integer, return stack as a bounded queue.
    int m_pc;
    int m_ras[$];
    bit m_ovf, m_unf, m_halt;

    function automatic void model_step(bit r, bit s, bit d, br_op_t op, bit z, int tgt);
        bit redirect = 0;
        int nxt      = 0;
        int abs_pc   = (m_pc / TMOD) * TMOD + tgt;
        int off      = (tgt >= TMOD / 2) ? tgt - TMOD : tgt;
        if (r) begin
            m_pc = 0; m_ras.delete(); m_ovf = 0; m_unf = 0; m_halt = 0;
            return;
        end
        if (s || m_halt) return;
        case (op)
            BR_ALW: begin nxt = abs_pc; redirect = 1; end
            BR_EZ:  if (z)  begin nxt = abs_pc; redirect = 1; end
            BR_NZ:  if (!z) begin nxt = abs_pc; redirect = 1; end
            BR_CALL: begin
                m_ras.push_back((m_pc + 1) % PCMOD);
                if (m_ras.size() > D) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1;
                end
                nxt = abs_pc; redirect = 1;
            end
            BR_RET: begin
                if (m_ras.size() > 0) begin nxt = m_ras.pop_back(); redirect = 1; end
                else m_unf = 1;
            end
`ifdef FETCH_REL_BRANCH_EN
            BR_REL_EZ: if (z)  begin nxt = (m_pc + off + PCMOD) % PCMOD; redirect = 1; end
            BR_REL_NZ: if (!z) begin nxt = (m_pc + off + PCMOD) % PCMOD; redirect = 1; end
`endif
            default: ;
        endcase
        if (redirect) m_pc = nxt;
        else if (d)   m_halt = 1;
        else          m_pc = (m_pc + 1) % PCMOD;
    endfunction

    initial begin
        // rst stl dn op z tgt | pc depth ovf unf hlt
        add(1,0,0,BR_NONE,0,8'h00, 'h000,0,0,0,0);
        for (int i = 1; i <= 5; i++) add(0,0,0,BR_NONE,0,0, i,0,0,0,0);
        add(0,0,0,BR_ALW ,0,8'hFF, 'h0FF,0,0,0,0);
        add(0,0,0,BR_NONE,0,8'h00, 'h100,0,0,0,0);
        add(0,0,0,BR_ALW ,0,8'hF0, 'h1F0,0,0,0,0);
        add(0,0,0,BR_ALW ,0,8'h22, 'h122,0,0,0,0);
        add(0,0,0,BR_EZ  ,0,8'h55, 'h123,0,0,0,0);
        add(0,0,0,BR_EZ  ,1,8'h40, 'h140,0,0,0,0);
        add(0,0,0,BR_NZ  ,1,8'h00, 'h141,0,0,0,0);
        add(0,0,0,BR_NZ  ,0,8'h00, 'h100,0,0,0,0);
        add(0,0,0,BR_ALW ,0,8'hFF, 'h1FF,0,0,0,0);
        add(0,0,0,BR_NONE,0,8'h00, 'h200,0,0,0,0);
        add(0,0,0,BR_ALW ,0,8'hFF, 'h2FF,0,0,0,0);
        add(0,0,0,BR_NONE,0,8'h00, 'h300,0,0,0,0);
        add(0,0,0,BR_ALW ,0,8'hFF, 'h3FF,0,0,0,0);
        add(0,0,0,BR_NONE,0,8'h00, 'h000,0,0,0,0);
        // Five calls into a four-deep stack, then five returns
        add(1,0,0,BR_NONE,0,8'h00, 'h000,0,0,0,0);
        add(0,0,0,BR_CALL,0,8'h10, 'h010,1,0,0,0);
        add(0,0,0,BR_CALL,0,8'h20, 'h020,2,0,0,0);
        add(0,0,0,BR_CALL,0,8'h30, 'h030,3,0,0,0);
        add(0,0,0,BR_CALL,0,8'h40, 'h040,4,0,0,0);
        add(0,0,0,BR_CALL,0,8'h50, 'h050,4,1,0,0);
        add(0,0,0,BR_RET ,0,8'h00, 'h041,3,1,0,0);
        add(0,0,0,BR_RET ,0,8'h00, 'h031,2,1,0,0);
        add(0,0,0,BR_RET ,0,8'h00, 'h021,1,1,0,0);
        add(0,0,0,BR_RET ,0,8'h00, 'h011,0,1,0,0);
        add(0,0,0,BR_RET ,0,8'h00, 'h012,0,1,1,0);
        // Stall during CALL, then the call fires once Stall drops
        add(1,0,0,BR_NONE,0,8'h00, 'h000,0,0,0,0);
        add(0,1,0,BR_CALL,0,8'h33, 'h000,0,0,0,0);
        add(0,1,1,BR_CALL,0,8'h33, 'h000,0,0,0,0);
        add(0,0,0,BR_CALL,0,8'h33, 'h033,1,0,0,0);
        add(0,1,0,BR_RET ,0,8'h00, 'h033,1,0,0,0);
        add(0,0,0,BR_RET ,0,8'h00, 'h001,0,0,0,0);
        // Done versus branch, then halt until reset
        add(0,0,1,BR_ALW ,0,8'h77, 'h077,0,0,0,0);
        add(0,0,1,BR_NONE,0,8'h00, 'h077,0,0,0,1);
        add(0,0,0,BR_ALW ,0,8'h10, 'h077,0,0,0,1);
        add(0,0,0,BR_CALL,0,8'h10, 'h077,0,0,0,1);
        add(0,0,0,BR_NONE,0,8'h00, 'h077,0,0,0,1);
        add(1,0,0,BR_NONE,0,8'h00, 'h000,0,0,0,0);
        // Reset wins over a stalled CALL; RET on empty stack honours Done
        add(0,0,0,BR_NONE,0,8'h00, 'h001,0,0,0,0);
        add(1,1,0,BR_CALL,0,8'h20, 'h000,0,0,0,0);
        add(0,0,1,BR_RET ,0,8'h00, 'h000,0,0,1,1);
        add(1,0,0,BR_NONE,0,8'h00, 'h000,0,0,0,0);
        for (int i = 1; i <= 5; i++) add(0,0,0,BR_NONE,0,0, i,0,0,0,0);
`ifdef FETCH_REL_BRANCH_EN
        add(0,0,0,BR_REL_NZ,0,8'hFA, 'h3FF,0,0,0,0);
        add(0,0,0,BR_REL_EZ,0,8'h05, 'h000,0,0,0,0);
        add(0,0,0,BR_REL_EZ,1,8'h03, 'h003,0,0,0,0);
`else
        add(0,0,0,BR_REL_NZ,0,8'hFA, 'h006,0,0,0,0);
        add(0,0,0,BR_REL_EZ,0,8'h05, 'h007,0,0,0,0);
        add(0,0,0,BR_REL_EZ,1,8'h03, 'h008,0,0,0,0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].stl, vecs[i].dn, vecs[i].op, vecs[i].z, vecs[i].tgt);
            check_outputs($sformatf("vec%0d", i), vecs[i].pc, vecs[i].depth,
                          vecs[i].ovf, vecs[i].unf, vecs[i].hlt);
        end

        // Randomized traffic against the reference model
        model_step(1, 0, 0, BR_NONE, 0, 0);
        drive(1, 0, 0, BR_NONE, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            bit     r = ($urandom_range(0, 49) == 0);
            bit     s = ($urandom_range(0, 5) == 0);
            bit     d = ($urandom_range(0, 29) == 0);
            br_op_t op = br_op_t'($urandom_range(0, 7));
            bit     z = 1'($urandom_range(0, 1));
            int     tgt = $urandom_range(0, TMOD - 1);
            model_step(r, s, d, op, z, tgt);
            drive(r, s, d, op, z, tgt);
            check_outputs($sformatf("rnd%0d", i), m_pc, m_ras.size(), m_ovf, m_unf, m_halt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
